// File: rtl/neuron_pkg.sv
// Shared defaults and FSM state type for the neuron accumulator.
package neuron_pkg;

  localparam int unsigned IN_W_DEF      = 8;
  localparam int unsigned ACC_W_DEF     = 16;
  localparam int unsigned MAX_TERMS_DEF = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_adder.sv
// Signed accumulate step with overflow detect; NEURON_ACC_SAT_EN selects clamping
// instead of two's-complement wrap on overflow.
module sat_adder #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] full;

  always_comb begin
    // One guard bit: the top two bits disagree exactly when ACC_W cannot hold the result.
    full = {a[ACC_W-1], a} + {{(ACC_W + 1 - IN_W){b[IN_W-1]}}, b};
    ovf  = full[ACC_W] ^ full[ACC_W-1];
`ifdef NEURON_ACC_SAT_EN
    if (ovf) begin
      sum = full[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end else begin
      sum = full[ACC_W-1:0];
    end
`else
    sum = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Packet-based signed accumulator: bias + sum of terms, result held until consumed.
// Build with NEURON_ACC_SAT_EN to saturate instead of wrap on overflow.
module neuron_accumulator
  import neuron_pkg::*;
#(
  parameter int unsigned IN_W      = IN_W_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned MAX_TERMS = MAX_TERMS_DEF,
  localparam int unsigned CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic [ACC_W-1:0] bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_inc;

  // The first beat of a packet starts from bias; later beats from the running sum.
  assign add_a   = (state_q == StAccum) ? acc_q : bias;
  assign cnt_inc = (state_q == StAccum) ? cnt_q + CNT_W'(1) : CNT_W'(1);

  sat_adder #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .a   (add_a),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = add_ovf | ((state_q == StAccum) & ovf_q);
          if (in_last) begin
            state_d = StHold;
          end else if (cnt_inc == CNT_W'(MAX_TERMS)) begin
            // Packet too long: close it out and flag it.
            state_d = StHold;
            ovf_d   = 1'b1;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q != StHold);
  assign out_valid = (state_q == StHold);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator: directed literal cases plus a
// randomized phase checked every cycle against a behavioural packet model.
module tb_neuron_accumulator;

  localparam int CNT_W = 5;
`ifdef NEURON_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic [15:0]      bias;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_bad = 0;

  neuron_accumulator #(
    .IN_W      (8),
    .ACC_W     (16),
    .MAX_TERMS (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: packet-level integer arithmetic, updated on each rising edge.
  bit m_init  = 0;
  bit m_hold  = 0;
  bit m_inpkt = 0;
  bit m_clean = 0;
  int m_sum   = 0;
  int m_cnt   = 0;
  bit m_ovf   = 0;

  always @(posedge clk) begin
    int base, full;
    bit ov;
    if (rst) begin
      m_init = 1; m_hold = 0; m_inpkt = 0; m_clean = 1;
      m_sum = 0; m_cnt = 0; m_ovf = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      if (!m_inpkt) begin
        base = int'($signed(bias));
        m_cnt = 0;
        m_ovf = 0;
      end else begin
        base = m_sum;
      end
      full = base + int'($signed(in_data));
      ov = (full > 32767) || (full < -32768);
      if (!ov) m_sum = full;
      else if (SAT) m_sum = (full > 0) ? 32767 : -32768;
      else m_sum = (full > 0) ? full - 65536 : full + 65536;
      m_cnt++;
      m_ovf = m_ovf | ov;
      m_clean = 0;
      if (in_last) begin
        m_hold = 1; m_inpkt = 0;
      end else if (m_cnt == 16) begin
        m_hold = 1; m_inpkt = 0; m_ovf = 1;
      end else begin
        m_inpkt = 1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", int'(in_ready), int'(!m_hold));
      chk("out_valid", int'(out_valid), int'(m_hold));
      if (m_hold || m_clean) begin
        chk("out_sum", int'($signed(out_sum)), m_sum);
        chk("out_ovf", int'(out_ovf), int'(m_ovf));
        chk("out_count", int'(out_count), m_cnt);
      end
    end
  end

  task automatic send(input int b, input int d, input bit l);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_data  = d[7:0];
    in_last  = l;
    bias     = b[15:0];
    ok = 0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_result(input string name, input int s, input int o, input int c);
    @(negedge clk);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_sum"}, int'($signed(out_sum)), s);
    chk({name, "_ovf"}, int'(out_ovf), o);
    chk({name, "_count"}, int'(out_count), c);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; bias = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_ready", int'(in_ready), 1);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_sum", int'($signed(out_sum)), 0);
    chk("reset_count", int'(out_count), 0);
    @(posedge clk); #1;

    // Basic packet with latency-1 result.
    send(100, 10, 0);
    send(100, -20, 0);
    send(100, 30, 1);
    expect_result("basic", 120, 0, 3);
    consume();

    // Overflow at the positive and negative extremes.
    send(32767, 1, 1);
    expect_result("pos_ovf", SAT ? 32767 : -32768, 1, 1);
    consume();
    send(-32768, -1, 1);
    expect_result("neg_ovf", SAT ? -32768 : 32767, 1, 1);
    consume();

    // Back-pressure in HOLD: input offered but not taken, result stable.
    send(7, 3, 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd55;
    in_last  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_sum", int'($signed(out_sum)), 10);
      chk("bp_count", int'(out_count), 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    consume();

    // Reset mid-packet discards it.
    send(0, 1, 0);
    send(0, 2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_sum", int'($signed(out_sum)), 0);
    chk("midrst_count", int'(out_count), 0);
    chk("midrst_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    send(0, 5, 1);
    expect_result("after_rst", 5, 0, 1);
    consume();

    // Over-length packet forced closed after 16 terms.
    for (int i = 0; i < 16; i++) send(0, 1, 0);
    expect_result("maxterms", 16, 1, 16);
    in_valid = 1'b1;
    in_data  = 8'd1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("maxterms_hold", int'(out_count), 16);
    in_valid = 1'b0;
    consume();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: bias = 16'h7fff;
        1: bias = 16'h8000;
        default: bias = 16'($urandom);
      endcase
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter IN_W, default 8, signed input term width.
REQ-002 SHALL have parameter ACC_W, default 16, signed accumulator/result width (ACC_W >= IN_W).
REQ-003 SHALL have parameter MAX_TERMS, default 16, maximum terms per packet; CNT_W = $clog2(MAX_TERMS+1).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports (name direction width meaning):
  clk        in   1       clock, rising edge
  rst        in   1       synchronous active-high reset
  in_valid   in   1       term valid
  in_ready   out  1       term accepted when in_valid && in_ready
  in_data    in   IN_W    signed term
  in_last    in   1       final term of packet
  bias       in   ACC_W   signed bias, sampled on first beat of packet
  out_valid  out  1       result valid
  out_ready  in   1       result consumed when out_valid && out_ready
  out_sum    out  ACC_W   signed accumulated result
  out_ovf    out  1       sticky overflow seen during packet
  out_count  out  CNT_W   terms accepted in packet

Function
REQ-006 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-007 SHALL drive in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
REQ-008 SHALL sign-extend in_data to ACC_W+1 and add in ACC_W+1 bits; overflow = bits [ACC_W] and [ACC_W-1] of the result differ.
REQ-009 SHALL, on an IDLE accept: acc = bias + in_data, count = 1, ovf = overflow of this add; go to HOLD if in_last else ACCUM.
REQ-010 SHALL, on an ACCUM accept: acc = acc + in_data, count += 1, ovf |= overflow; go to HOLD if in_last.
REQ-011 SHALL force packet end (go to HOLD, set ovf) when count reaches MAX_TERMS without in_last.
REQ-012 SHALL assert out_valid exactly in HOLD, first cycle after the last beat is accepted (latency 1).
REQ-013 SHALL hold out_sum/out_ovf/out_count stable while out_valid && !out_ready.
REQ-014 SHALL return HOLD -> IDLE on out_ready; next packet accepted the following cycle (one bubble per packet).
REQ-015 SHALL ignore in_valid/in_data/in_last/bias when in_ready = 0, and bias in ACCUM.

Reset
REQ-016 SHALL on rst: state IDLE, out_valid 0, out_sum 0, out_ovf 0, out_count 0, in_ready 1 the cycle after rst deasserts.
REQ-017 SHALL discard any partial packet on rst mid-operation; rst takes priority over all handshakes.

Configuration
REQ-018 SHALL support macro NEURON_ACC_SAT_EN: defined -> on overflow clamp acc to +2^(ACC_W-1)-1 or -2^(ACC_W-1) per sign of the true result; undefined -> two's-complement wrap. out_ovf behaviour identical in both.

Structure
REQ-019 SHALL take IN_W/ACC_W defaults and state enum type from shared package neuron_pkg.
REQ-020 SHALL place the add/overflow/clamp datapath in combinational sub-module sat_adder.

Verification
REQ-021 bias=100, terms 10,-20,30(last) -> out_sum=120, out_ovf=0, out_count=3, out_valid one cycle after last.
REQ-022 bias=32767, term 1(last) -> SAT_EN: out_sum=32767, out_ovf=1; else out_sum=-32768, out_ovf=1.
REQ-023 bias=-32768, term -1(last) -> SAT_EN: out_sum=-32768; else 32767; out_ovf=1 both.
REQ-024 out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, outputs stable, no term counted.
REQ-025 rst after 2 accepted terms -> all outputs 0; next packet bias=0, term 5(last) -> out_sum=5, out_count=1.
REQ-026 17 terms of 1, no in_last, bias=0 -> HOLD after 16th, out_sum=16, out_count=16, out_ovf=1.
